// File: rtl/display_arb_pkg.sv
// Shared types and constants for the display arbiter and its round-robin picker.
package display_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int unsigned NREQ_MAX      = 4;
    localparam int unsigned SLICE_W       = 64;
    localparam int unsigned DISP_W        = 32;
    localparam int unsigned PAD_W         = NREQ_MAX * SLICE_W;
    localparam logic [31:0] BLANK_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
module rr_picker
    import display_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] pick,
    output logic [1:0]      idx
);

    logic [NREQ_MAX-1:0] req_pad;
    logic [NREQ_MAX-1:0] pick_pad;
    logic                found;
    logic [1:0]          cand;

    assign req_pad = NREQ_MAX'(req);

    // Scan candidates in pointer order; the first hit wins.
    always_comb begin
        pick_pad = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 2'((32'(ptr) + k) % NREQ);
            if (!found && req_pad[cand]) begin
                found          = 1'b1;
                idx            = cand;
                pick_pad[cand] = 1'b1;
            end
        end
    end

    assign pick = pick_pad[NREQ-1:0];

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the two seven-segment display words with min/max grant hold.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MIN_HOLD = 4,
    parameter int unsigned MAX_HOLD = 1024,
    parameter logic [31:0] BLANK    = BLANK_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*SLICE_W-1:0] data,
    output logic [NREQ-1:0]         gnt,
    output logic [1:0]              owner,
    output logic                    busy,
    output logic [DISP_W-1:0]       hex_display,
    output logic [DISP_W-1:0]       hex_display2
);

    localparam int unsigned HOLD_SAT = (MIN_HOLD > MAX_HOLD) ? MIN_HOLD : MAX_HOLD;
    localparam int unsigned CNT_W    = $clog2(HOLD_SAT + 1);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [NREQ-1:0]     gnt_d;
    logic [1:0]          owner_d;
    logic                busy_d;
    logic [DISP_W-1:0]   hex_d, hex2_d;

    logic [NREQ-1:0]     pick;
    logic [1:0]          pick_idx;
    logic [NREQ_MAX-1:0] req_pad;
    logic [PAD_W-1:0]    data_pad;
    logic                own_req;
    logic                others;
    logic                min_met;
    logic                max_met;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    assign req_pad  = NREQ_MAX'(req);
    assign data_pad = PAD_W'(data);
    assign own_req  = req_pad[owner];
    assign others   = |(req & ~gnt);
    assign min_met  = (32'(cnt_q) + 32'd1) >= MIN_HOLD;
    assign max_met  = (MAX_HOLD != 0) && ((32'(cnt_q) + 32'd1) >= MAX_HOLD);

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt;
        owner_d = owner;
        busy_d  = busy;
        hex_d   = hex_display;
        hex2_d  = hex_display2;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (cnt_q != CNT_W'(HOLD_SAT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (own_req) begin
                    hex_d  = data_pad[{owner, 6'd0}  +: DISP_W];
                    hex2_d = data_pad[{owner, 6'd32} +: DISP_W];
                end
                if ((!own_req && min_met) || (max_met && others)) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                ptr_d   = 2'((32'(owner) + 32'd1) % NREQ);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            gnt          <= '0;
            owner        <= '0;
            busy         <= 1'b0;
            hex_display  <= BLANK;
            hex_display2 <= BLANK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            gnt          <= gnt_d;
            owner        <= owner_d;
            busy         <= busy_d;
            hex_display  <= hex_d;
            hex_display2 <= hex2_d;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized self-checking bench for display_arbiter against a grant-age reference model.
module tb_display_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned MIN_HOLD = 4;
    localparam int unsigned MAX_HOLD = 16;
    localparam logic [31:0] BLANK    = 32'hFFFF_FFFF;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [255:0] data;
    logic [3:0]   gnt;
    logic [1:0]   owner;
    logic         busy;
    logic [31:0]  hex_display;
    logic [31:0]  hex_display2;

    int checks;
    int errors;

    // Reference model: owner index (-1 = none), grant age in cycles, dead cycles left.
    int          m_own;
    int          m_age;
    int          m_cool;
    int          m_ptr;
    int          m_last;
    logic [31:0] m_h1;
    logic [31:0] m_h2;

    display_arbiter #(
        .NREQ     (NREQ),
        .MIN_HOLD (MIN_HOLD),
        .MAX_HOLD (MAX_HOLD),
        .BLANK    (BLANK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data         (data),
        .gnt          (gnt),
        .owner        (owner),
        .busy         (busy),
        .hex_display  (hex_display),
        .hex_display2 (hex_display2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_own  = -1;
        m_age  = 0;
        m_cool = 0;
        m_ptr  = 0;
        m_last = 0;
        m_h1   = BLANK;
        m_h2   = BLANK;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [255:0] d);
        logic oth;
        if (m_own >= 0) begin
            if (r[m_own]) begin
                m_h1 = d[m_own*64 +: 32];
                m_h2 = d[m_own*64+32 +: 32];
            end
            oth = (r & ~(4'b0001 << m_own)) != 4'b0;
            if ((!r[m_own] && m_age >= int'(MIN_HOLD)) ||
                (MAX_HOLD != 0 && m_age >= int'(MAX_HOLD) && oth)) begin
                m_ptr  = (m_own + 1) % NREQ;
                m_own  = -1;
                m_cool = 1;
            end else begin
                m_age++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 4'b0) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (m_own < 0 && r[c]) m_own = c;
            end
            m_last = m_own;
            m_age  = 1;
        end
    endtask

    function automatic logic [70:0] model_vec();
        logic [3:0] g;
        g = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
        return {g, (m_own >= 0), 2'(m_last), m_h1, m_h2};
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Apply inputs before the next rising edge, advance the model, land on the falling edge.
    task automatic tick(input logic [3:0] r, input logic [255:0] d);
        req  = r;
        data = d;
        model_step(r, d);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        req  = '0;
        data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({gnt, busy, owner, hex_display, hex_display2} !== {4'b0, 1'b0, 2'b0, BLANK, BLANK}) begin
            errors++;
            $display("FAIL reset_values got %h want %h", {gnt, busy, owner, hex_display, hex_display2},
                     {4'b0, 1'b0, 2'b0, BLANK, BLANK});
        end
        for (int i = 0; i < 10; i++) begin
            tick(4'b0000, rand_data());
            checks++;
            if ({gnt, busy, hex_display, hex_display2} !== {4'b0, 1'b0, BLANK, BLANK}) begin
                errors++;
                $display("FAIL idle_blank cycle %0d got %h want %h", i, {gnt, busy, hex_display, hex_display2},
                         {4'b0, 1'b0, BLANK, BLANK});
            end
        end
    endtask

    task automatic test_single();
        logic [255:0] d;
        d = rand_data();
        d[64 +: 64] = 64'h1234_5678_9ABC_DEF0;
        tick(4'b0010, d);
        checks++;
        if (gnt !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt got %b/%b want 0010/1", gnt, busy);
        end
        tick(4'b0010, d);
        checks++;
        if (hex_display !== 32'h9ABC_DEF0 || hex_display2 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_data got %h %h want 9abcdef0 12345678", hex_display, hex_display2);
        end
        for (int i = 0; i < 8; i++) begin
            tick(4'b0000, rand_data());
            checks++;
            if ({gnt, busy, owner, hex_display, hex_display2} !== model_vec()) begin
                errors++;
                $display("FAIL single_drain got %h want %h", {gnt, busy, owner, hex_display, hex_display2}, model_vec());
            end
        end
    endtask

    task automatic test_round_robin();
        int ord [5];
        int len [5];
        int gap [4];
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        int ng, cur_len, cur_idx, zeros;
        logic [3:0] prev;
        apply_reset();
        ng = 0; cur_len = 0; cur_idx = -1; zeros = 0; prev = 4'b0;
        for (int i = 0; i < 5; i++) begin ord[i] = -1; len[i] = 0; end
        for (int i = 0; i < 4; i++) gap[i] = 0;
        for (int cyc = 0; cyc < 150 && ng < 5; cyc++) begin
            tick(4'b1111, rand_data());
            checks++;
            if ({gnt, busy, owner, hex_display, hex_display2} !== model_vec()) begin
                errors++;
                $display("FAIL rr_model got %h want %h", {gnt, busy, owner, hex_display, hex_display2}, model_vec());
            end
            if (gnt != 4'b0) begin
                if (prev == 4'b0) begin
                    if (ng > 0) gap[ng-1] = zeros;
                    cur_len = 0;
                    cur_idx = onehot_idx(gnt);
                end
                cur_len++;
            end else begin
                if (prev != 4'b0) begin
                    ord[ng] = cur_idx;
                    len[ng] = cur_len;
                    ng++;
                    zeros = 0;
                end
                zeros++;
            end
            prev = gnt;
        end
        checks++;
        if (ng != 5) begin
            errors++;
            $display("FAIL rr_count got %0d grants want 5", ng);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ord[i] != exp_ord[i] || len[i] != int'(MAX_HOLD)) begin
                errors++;
                $display("FAIL rr_grant %0d got owner %0d len %0d want owner %0d len %0d",
                         i, ord[i], len[i], exp_ord[i], MAX_HOLD);
            end
        end
        // gnt falls in cycle n (RELEASE) and the next grant rises in n+2.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gap[i] != 2) begin
                errors++;
                $display("FAIL rr_gap %0d got %0d low cycles want 2", i, gap[i]);
            end
        end
    endtask

    task automatic test_pulse();
        logic [255:0] d3;
        logic [31:0]  exp_h1;
        int           glen;
        apply_reset();
        d3 = rand_data();
        exp_h1 = d3[3*64 +: 32];
        repeat (6) tick(4'b1000, d3);
        repeat (8) tick(4'b0000, rand_data());
        checks++;
        if (hex_display !== exp_h1 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL pulse_preload got %h/%b want %h/0000", hex_display, gnt, exp_h1);
        end
        tick(4'b0001, rand_data());
        glen = (gnt == 4'b0001) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            tick(4'b0000, rand_data());
            if (gnt == 4'b0001) glen++;
            checks++;
            if ({gnt, busy, owner, hex_display, hex_display2} !== model_vec()) begin
                errors++;
                $display("FAIL pulse_model got %h want %h", {gnt, busy, owner, hex_display, hex_display2}, model_vec());
            end
        end
        checks++;
        if (glen != int'(MIN_HOLD) || hex_display !== exp_h1) begin
            errors++;
            $display("FAIL pulse_hold got len %0d disp %h want len %0d disp %h", glen, hex_display, MIN_HOLD, exp_h1);
        end
    endtask

    task automatic test_preempt();
        int len2, zeros;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick(4'b0100, rand_data());
            checks++;
            if (gnt !== 4'b0100) begin
                errors++;
                $display("FAIL preempt_own2 cycle %0d got %b want 0100", i, gnt);
            end
        end
        len2 = 5;
        for (int i = 0; i < 40; i++) begin
            tick(4'b0110, rand_data());
            checks++;
            if ({gnt, busy, owner, hex_display, hex_display2} !== model_vec()) begin
                errors++;
                $display("FAIL preempt_model got %h want %h", {gnt, busy, owner, hex_display, hex_display2}, model_vec());
            end
            if (gnt != 4'b0100) break;
            len2++;
        end
        checks++;
        if (len2 != int'(MAX_HOLD)) begin
            errors++;
            $display("FAIL preempt_len got %0d want %0d", len2, MAX_HOLD);
        end
        zeros = 1;
        for (int i = 0; i < 10; i++) begin
            tick(4'b0110, rand_data());
            if (gnt != 4'b0) break;
            zeros++;
        end
        checks++;
        if (zeros != 2 || gnt !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL preempt_next got gap %0d gnt %b owner %0d want gap 2 gnt 0010 owner 1", zeros, gnt, owner);
        end
        repeat (10) tick(4'b0000, rand_data());
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (6) tick(4'b0100, rand_data());
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_pre got %b want 0100", gnt);
        end
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({gnt, busy, owner, hex_display, hex_display2} !== {4'b0, 1'b0, 2'b0, BLANK, BLANK}) begin
            errors++;
            $display("FAIL midrst_async got %h want %h", {gnt, busy, owner, hex_display, hex_display2},
                     {4'b0, 1'b0, 2'b0, BLANK, BLANK});
        end
        @(negedge clk);
        rst = 1'b0;
        tick(4'b1001, rand_data());
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_contest got %b want 0001", gnt);
        end
        repeat (8) tick(4'b0000, rand_data());
    endtask

    task automatic test_random();
        logic [3:0]   r;
        logic [255:0] d;
        apply_reset();
        r = 4'b0;
        d = rand_data();
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            if ($urandom_range(0, 2) == 0) d = rand_data();
            tick(r, d);
            checks++;
            if ({gnt, busy, owner, hex_display, hex_display2} !== model_vec()) begin
                errors++;
                $display("FAIL random_model cycle %0d got %h want %h", i,
                         {gnt, busy, owner, hex_display, hex_display2}, model_vec());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = '0;
        data   = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_pulse();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
